// File: rtl/wb_arbiter_rr_if.sv
// wb_arbiter_rr_if: Wishbone bundle for N masters and one slave; slave modport faces the masters, master modport faces the slave
interface wb_arbiter_rr_if #(
  parameter int N_MASTERS = 4,
  parameter int AW = 30,
  parameter int DW = 32
);
  logic [N_MASTERS*AW-1:0] m_adr_i;
  logic [N_MASTERS*DW-1:0] m_dat_i;
  logic [N_MASTERS*DW/8-1:0] m_sel_i;
  logic [N_MASTERS*3-1:0] m_cti_i;
  logic [N_MASTERS*2-1:0] m_bte_i;
  logic [N_MASTERS-1:0] m_cyc_i;
  logic [N_MASTERS-1:0] m_stb_i;
  logic [N_MASTERS-1:0] m_we_i;
  logic [DW-1:0] m_dat_o;
  logic [N_MASTERS-1:0] m_ack_o;
  logic [N_MASTERS-1:0] m_err_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [DW/8-1:0] s_sel_o;
  logic [2:0] s_cti_o;
  logic [1:0] s_bte_o;
  logic s_cyc_o;
  logic s_stb_o;
  logic s_we_o;
  logic [DW-1:0] s_dat_i;
  logic s_ack_i;
  logic s_err_i;
  modport slave (
    input m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i, m_cyc_i, m_stb_i, m_we_i,
    output m_dat_o, m_ack_o, m_err_o
  );
  modport master (
    output s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o, s_we_o,
    input s_dat_i, s_ack_i, s_err_i
  );
endinterface

// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr: N-master round-robin Wishbone arbiter with bus-timeout watchdog
module wb_arbiter_rr #(
  parameter int N_MASTERS = 4,
  parameter int AW = 30,
  parameter int DW = 32,
  parameter int TIMEOUT = 16
) (
  input logic sys_clk,
  input logic sys_rst_n,
  wb_arbiter_rr_if.slave m,
  wb_arbiter_rr_if.master s,
  output logic [N_MASTERS-1:0] grant_o
);
  localparam int GW = $clog2(N_MASTERS);
  localparam int SW = DW/8;
  logic [GW-1:0] g_q, g_d, idx;
  logic to_err_q;
  always_comb begin
    s.s_adr_o = '0;
    s.s_dat_o = '0;
    s.s_sel_o = '0;
    s.s_cti_o = '0;
    s.s_bte_o = '0;
    s.s_we_o = 1'b0;
    for (int k = 0; k < N_MASTERS; k++)
      if (g_q == GW'(k)) begin
        s.s_adr_o = m.m_adr_i[k*AW +: AW];
        s.s_dat_o = m.m_dat_i[k*DW +: DW];
        s.s_sel_o = m.m_sel_i[k*SW +: SW];
        s.s_cti_o = m.m_cti_i[k*3 +: 3];
        s.s_bte_o = m.m_bte_i[k*2 +: 2];
        s.s_we_o = m.m_we_i[k];
      end
  end
  assign s.s_cyc_o = m.m_cyc_i[g_q] & ~to_err_q;
  assign s.s_stb_o = m.m_stb_i[g_q] & ~to_err_q;
  assign grant_o = N_MASTERS'(1) << g_q;
  assign m.m_dat_o = s.s_dat_i;
  assign m.m_ack_o = {N_MASTERS{s.s_ack_i & ~to_err_q}} & grant_o;
  assign m.m_err_o = {N_MASTERS{s.s_err_i | to_err_q}} & grant_o;
  always_comb begin
    g_d = g_q;
    idx = '0;
    for (int i = N_MASTERS; i >= 1; i--) begin
      idx = GW'((int'(g_q) + i) % N_MASTERS);
      if (m.m_cyc_i[idx]) g_d = idx;
    end
    if (m.m_cyc_i[g_q]) g_d = g_q;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) g_q <= '0;
    else g_q <= g_d;
  if (TIMEOUT > 0) begin : g_wd
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic to_err_d, busy;
    always_comb begin
      busy = s.s_cyc_o & s.s_stb_o & ~s.s_ack_i & ~s.s_err_i;
      to_err_d = busy && cnt_q == CW'(TIMEOUT - 1);
      cnt_d = busy && !to_err_d ? cnt_q + 1'b1 : '0;
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
        cnt_q <= '0;
        to_err_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        to_err_q <= to_err_d;
      end
  end else begin : g_nowd
    assign to_err_q = 1'b0;
  end
endmodule

// File: tb/tb_wb_arbiter_rr.sv
// tb_wb_arbiter_rr: directed scoreboard bench for the round-robin Wishbone arbiter
module tb_wb_arbiter_rr;
  localparam int N = 4;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TO = 16;
  typedef struct {
    string tag;
    logic [63:0] v;
  } exp_t;
  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic [N-1:0] grant;
  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  wb_arbiter_rr_if #(.N_MASTERS(N), .AW(AW), .DW(DW)) bus ();
  wb_arbiter_rr #(.N_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .m(bus),
    .s(bus),
    .grant_o(grant)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic want(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic got(input logic [63:0] obs);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL underflow: observed %0h with no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        mismatched++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.v);
      end
    end
  endtask
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic req(input int k, input logic on);
    bus.m_cyc_i[k] = on;
    bus.m_stb_i[k] = on;
  endtask
  initial begin
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.m_cti_i = '0;
    bus.m_bte_i = '0;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i = '0;
    bus.s_dat_i = 32'hCAFE_F00D;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
    for (int k = 0; k < N; k++) begin
      bus.m_adr_i[k*AW +: AW] = AW'(32'h100 + k);
      bus.m_dat_i[k*DW +: DW] = DW'(32'h1111_1111 * (k + 1));
      bus.m_sel_i[k*4 +: 4] = 4'hF;
      bus.m_we_i[k] = k[0];
    end
    sys_rst_n = 1'b1;
    #1 sys_rst_n = 1'b0;
    #1;
    want("rst_grant", 1); want("rst_ack", 0); want("rst_err", 0);
    got(grant); got(bus.m_ack_o); got(bus.m_err_o);
    tick();
    tick();
    sys_rst_n = 1'b1;
    req(2, 1'b1);
    want("park_cyc", 0); want("park_grant", 1);
    #1 got(bus.s_cyc_o); got(grant);
    tick();
    bus.s_ack_i = 1'b1;
    want("burst_grant", 4); want("burst_ack", 4); want("burst_adr", 'h102);
    want("burst_wdat", 32'h3333_3333); want("burst_we", 0); want("rdata", 32'hCAFE_F00D);
    #1 got(grant); got(bus.m_ack_o); got(bus.s_adr_o);
    got(bus.s_dat_o); got(bus.s_we_o); got(bus.m_dat_o);
    tick();
    want("burst_hold", 4);
    #1 got(grant);
    sys_rst_n = 1'b0;
    bus.s_ack_i = 1'b0;
    want("mid_rst_grant", 1); want("mid_rst_ack", 0); want("mid_rst_err", 0); want("mid_rst_adr", 'h100);
    #1 got(grant); got(bus.m_ack_o); got(bus.m_err_o); got(bus.s_adr_o);
    sys_rst_n = 1'b1;
    want("rel_adr", 'h100); want("rel_cyc", 0);
    #1 got(bus.s_adr_o); got(bus.s_cyc_o);
    req(2, 1'b0);
    tick();
    want("idle_park", 1);
    #1 got(grant);
    req(1, 1'b1); req(2, 1'b1); req(3, 1'b1);
    want("rot_first_dead", 0); want("rot_first_grant", 1);
    #1 got(bus.s_cyc_o); got(grant);
    for (int k = 1; k <= 3; k++) begin
      tick();
      bus.s_ack_i = 1'b1;
      want($sformatf("rot_grant%0d", k), 1 << k); want($sformatf("rot_cyc%0d", k), 1);
      want($sformatf("rot_ack%0d", k), 1 << k); want($sformatf("rot_adr%0d", k), 'h100 + k);
      #1 got(grant); got(bus.s_cyc_o); got(bus.m_ack_o); got(bus.s_adr_o);
      tick();
      bus.s_ack_i = 1'b0;
      if (k < 3) begin
        req(k, 1'b0);
        want($sformatf("rot_dead%0d", k), 0); want($sformatf("rot_dead_grant%0d", k), 1 << k);
        #1 got(bus.s_cyc_o); got(grant);
      end
    end
    req(0, 1'b1); req(2, 1'b1);
    want("wrap_hold", 8);
    #1 got(grant);
    tick();
    req(3, 1'b0);
    want("wrap_dead", 0);
    #1 got(bus.s_cyc_o);
    tick();
    want("wrap_grant", 1); want("wrap_adr", 'h100);
    #1 got(grant); got(bus.s_adr_o);
    req(0, 1'b0);
    want("hold_pre_dead", 0);
    #1 got(bus.s_cyc_o);
    tick();
    req(0, 1'b1);
    bus.s_ack_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) tick();
      want($sformatf("hold_grant%0d", b), 4); want($sformatf("hold_ack%0d", b), 4);
      #1 got(grant); got(bus.m_ack_o);
    end
    tick();
    req(2, 1'b0);
    bus.s_ack_i = 1'b0;
    want("hold_rel_grant", 4); want("hold_rel_cyc", 0);
    #1 got(grant); got(bus.s_cyc_o);
    tick();
    want("hold_switch", 1);
    #1 got(grant);
    req(0, 1'b0);
    req(1, 1'b1);
    for (int c = 0; c <= 66; c++) begin
      logic e;
      tick();
      bus.s_ack_i = (c == 49 || c == 66);
      e = (c == 16 || c == 33 || c == 66);
      want($sformatf("to_err@%0d", c), e ? 2 : 0);
      want($sformatf("to_stb@%0d", c), e ? 0 : 1);
      want($sformatf("to_ack@%0d", c), c == 49 ? 2 : 0);
      #1 got(bus.m_err_o); got(bus.s_stb_o); got(bus.m_ack_o);
    end
    tick();
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b1;
    want("slave_err", 2); want("slave_err_ack", 0);
    #1 got(bus.m_err_o); got(bus.m_ack_o);
    bus.s_err_i = 1'b0;
    req(1, 1'b0);
    tick();
    compared++;
    assert (sb.size() == 0) else begin
      mismatched++;
      $error("FAIL leftover: %0d expectations unconsumed, 0 required", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
